// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared opcodes, FSM states and size defaults for the op sequencer
// Purpose: common definitions imported by the sequencer, its ALU and its interface.
// Ports: none (package).
package reg_bank_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int NREGS_DEF  = 8;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_LDI = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bank_op_sequencer_if.sv
// rtl/reg_bank_op_sequencer_if.sv - command handshake and register-bank bus bundle
// Purpose: groups the command channel and the register-bank read/write port.
// Ports: master = command source + bank (drives cmd_*, rf_rdata_*),
//        slave  = sequencer (drives cmd_ready, rf_raddr_*, rf_we/waddr/wdata, done).
interface reg_bank_op_sequencer_if
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = $clog2(NREGS_DEF)
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [DATA_W-1:0] cmd_imm;
  logic [ADDR_W-1:0] rf_raddr_a;
  logic [ADDR_W-1:0] rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rf_rdata_a, rf_rdata_b,
    input  cmd_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, rf_rdata_a, rf_rdata_b,
    output cmd_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata, done
  );

endinterface

// File: rtl/reg_bank_op_sequencer_seq_alu.sv
// rtl/reg_bank_op_sequencer_seq_alu.sv - combinational ALU used during EXEC
// Purpose: computes the write-back value and carry/borrow for one opcode.
// Ports: op, a, b, imm in; result, carry out (carry only meaningful for ADD/SUB).
module seq_alu
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    // One extra bit so the MSB carries out of ADD / borrows out of SUB.
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        carry  = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/reg_bank_op_sequencer.sv
// rtl/reg_bank_op_sequencer.sv - sequences opcode commands into register-bank read/exec/write traffic
// Purpose: accepts one command at a time, reads rs1/rs2, computes in seq_alu, writes rd.
//          IDLE -> READ -> EXEC -> WRITE -> IDLE, one command per 4 cycles.
// Ports: clk, rst (sync, active-high); bus (slave side of reg_bank_op_sequencer_if);
//        flag_z, flag_c only when SEQ_FLAGS_EN is defined.
// Config: SEQ_FLAGS_EN adds zero and carry/borrow flags updated by ADD/SUB/AND/OR/XOR.
module reg_bank_op_sequencer
  import reg_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_bank_op_sequencer_if.slave bus
`ifdef SEQ_FLAGS_EN
  ,
  output logic                   flag_z,
  output logic                   flag_c
`endif
);

  state_t            state_q, state_d;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0] imm_q, opa_q, opb_q, res_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;

  logic              cmd_ready;
  logic [ADDR_W-1:0] raddr_a, raddr_b, waddr;
  logic [DATA_W-1:0] wdata;
  logic              we, done;

  seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (opa_q),
    .b      (opb_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    raddr_a   = '0;
    raddr_b   = '0;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = S_READ;
      end
      S_READ: begin
        raddr_a = rs1_q;
        raddr_b = rs2_q;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = S_WRITE;
      S_WRITE: begin
        // Reset during WRITE drops the write-back: the bank must not commit it.
        we      = (op_q != OP_NOP) && !rst;
        done    = !rst;
        waddr   = rd_q;
        wdata   = res_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_NOP;
      rd_q  <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      imm_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.cmd_valid) begin
        op_q  <= bus.cmd_op;
        rd_q  <= bus.cmd_rd;
        rs1_q <= bus.cmd_rs1;
        rs2_q <= bus.cmd_rs2;
        imm_q <= bus.cmd_imm;
      end
      // Operands are frozen here, so rd == rs1/rs2 sees the pre-write values.
      if (state_q == S_READ) begin
        opa_q <= bus.rf_rdata_a;
        opb_q <= bus.rf_rdata_b;
      end
      if (state_q == S_EXEC) res_q <= alu_result;
    end
  end

`ifdef SEQ_FLAGS_EN
  logic carry_q;

  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else if (state_q == S_EXEC) carry_q <= alu_carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (state_q == S_WRITE) begin
      case (op_q)
        OP_ADD, OP_SUB: begin
          flag_z <= (res_q == '0);
          flag_c <= carry_q;
        end
        OP_AND, OP_OR, OP_XOR: begin
          flag_z <= (res_q == '0);
          flag_c <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_carry;
  assign unused_carry = alu_carry;
`endif

  assign bus.cmd_ready  = cmd_ready;
  assign bus.rf_raddr_a = raddr_a;
  assign bus.rf_raddr_b = raddr_b;
  assign bus.rf_we      = we;
  assign bus.rf_waddr   = waddr;
  assign bus.rf_wdata   = wdata;
  assign bus.done       = done;

endmodule

// File: tb/tb_reg_bank_op_sequencer.sv
// tb/tb_reg_bank_op_sequencer.sv - self-checking bench for reg_bank_op_sequencer
module tb_reg_bank_op_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   last_gap = 0;

  logic [7:0] bank [8];
  logic [7:0] mdl  [8];
  logic       exp_z = 1'b0;
  logic       exp_c = 1'b0;

  reg_bank_op_sequencer_if #(.DATA_W(8), .ADDR_W(3)) ifc ();

`ifdef SEQ_FLAGS_EN
  logic flag_z, flag_c;
  reg_bank_op_sequencer dut (.clk(clk), .rst(rst), .bus(ifc), .flag_z(flag_z), .flag_c(flag_c));
`else
  reg_bank_op_sequencer dut (.clk(clk), .rst(rst), .bus(ifc));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ifc.rf_rdata_a = bank[ifc.rf_raddr_a];
  assign ifc.rf_rdata_b = bank[ifc.rf_raddr_b];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= 8'h00;
    end else if (ifc.rf_we) begin
      bank[ifc.rf_waddr] <= ifc.rf_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_flags(input string tag);
`ifdef SEQ_FLAGS_EN
    chk({tag, "_z"}, flag_z, exp_z);
    chk({tag, "_c"}, flag_c, exp_c);
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    exp_z = 1'b0;
    exp_c = 1'b0;
  endtask

  // Idle cycles with cmd_valid low: nothing may be written or retired.
  task automatic idle(input int n);
    ifc.cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_we", ifc.rf_we, 1'b0);
      chk("idle_done", ifc.done, 1'b0);
      chk("idle_ready", ifc.cmd_ready, 1'b1);
      chk_flags("idle_flag");
    end
  endtask

  // Present one command (called at a negedge) and follow it to its WRITE cycle.
  // cmd_valid is left high so a following call is back-to-back.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input logic [7:0] imm);
    int a, b, r, n;
    logic c, wr, sets_flags;
    a = int'(mdl[rs1]);
    b = int'(mdl[rs2]);
    c = 1'b0;
    wr = 1'b1;
    sets_flags = 1'b1;
    case (op)
      3'd1: begin r = (a + b) % 256; c = (a + b) > 255; end
      3'd2: begin r = (a - b + 256) % 256; c = a < b; end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: begin r = a; sets_flags = 1'b0; end
      3'd7: begin r = int'(imm); sets_flags = 1'b0; end
      default: begin r = 0; wr = 1'b0; sets_flags = 1'b0; end
    endcase
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = op;
    ifc.cmd_rd    = rd;
    ifc.cmd_rs1   = rs1;
    ifc.cmd_rs2   = rs2;
    ifc.cmd_imm   = imm;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", (n < 10), 1'b1);
    if (n >= 10) return;
    last_gap = cyc - last_acc;
    last_acc = cyc;
    @(negedge clk);
    chk("read_ready", ifc.cmd_ready, 1'b0);
    chk("read_we", ifc.rf_we, 1'b0);
    chk("read_done", ifc.done, 1'b0);
    chk("read_raddr_a", ifc.rf_raddr_a, rs1);
    chk("read_raddr_b", ifc.rf_raddr_b, rs2);
    chk_flags("read_flag");
    @(negedge clk);
    chk("exec_ready", ifc.cmd_ready, 1'b0);
    chk("exec_we", ifc.rf_we, 1'b0);
    chk("exec_done", ifc.done, 1'b0);
    @(negedge clk);
    chk("write_ready", ifc.cmd_ready, 1'b0);
    chk("write_done", ifc.done, 1'b1);
    chk("write_we", ifc.rf_we, wr);
    if (wr) begin
      chk("write_waddr", ifc.rf_waddr, rd);
      chk("write_wdata", ifc.rf_wdata, r[7:0]);
      mdl[rd] = r[7:0];
    end
    if (sets_flags) begin
      exp_z = (r == 0);
      exp_c = c;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op = 3'd0; ifc.cmd_rd = 3'd0; ifc.cmd_rs1 = 3'd0; ifc.cmd_rs2 = 3'd0; ifc.cmd_imm = 8'h00;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ifc.cmd_ready, 1'b1);
    chk("rst_we", ifc.rf_we, 1'b0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_raddr_a", ifc.rf_raddr_a, 3'd0);
    chk("rst_raddr_b", ifc.rf_raddr_b, 3'd0);
    chk("rst_waddr", ifc.rf_waddr, 3'd0);
    chk("rst_wdata", ifc.rf_wdata, 8'h00);
    chk_flags("rst_flag");
    rst = 1'b0;
    idle(10);

    // LDI, then ADD with carry out, then SUB with rd == rs1 == rs2.
    do_cmd(3'd7, 3'd3, 3'd0, 3'd0, 8'hA5);
    idle(1);
    do_cmd(3'd7, 3'd1, 3'd0, 3'd0, 8'hF0);
    do_cmd(3'd7, 3'd2, 3'd0, 3'd0, 8'h20);
    do_cmd(3'd1, 3'd4, 3'd1, 3'd2, 8'h00);
    idle(2);
    do_cmd(3'd7, 3'd5, 3'd0, 3'd0, 8'h07);
    do_cmd(3'd2, 3'd5, 3'd5, 3'd5, 8'h00);
    idle(2);

    // NOP then MOV with cmd_valid held: MOV accepted 4 cycles after NOP.
    do_cmd(3'd0, 3'd0, 3'd0, 3'd0, 8'h00);
    do_cmd(3'd6, 3'd6, 3'd3, 3'd0, 8'h00);
    chk("b2b_gap", last_gap, 4);
    idle(2);

    // Reset during EXEC of an XOR drops the write.
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 3'd5; ifc.cmd_rd = 3'd7; ifc.cmd_rs1 = 3'd1; ifc.cmd_rs2 = 3'd3;
    @(negedge clk);
    ifc.cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_we", ifc.rf_we, 1'b0);
    chk("midrst_done", ifc.done, 1'b0);
    chk("midrst_ready", ifc.cmd_ready, 1'b1);
    rst = 1'b0;
    clear_model();
    idle(4);

    // Reset and cmd_valid together: nothing accepted.
    ifc.cmd_valid = 1'b1; ifc.cmd_op = 3'd7; ifc.cmd_rd = 3'd7; ifc.cmd_imm = 8'hFF;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifc.cmd_valid = 1'b0;
    chk("rstwin_ready", ifc.cmd_ready, 1'b1);
    idle(4);

    // Random commands, mostly back-to-back, checked against the model.
    for (int i = 0; i < 40; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);
    for (int i = 0; i < 8; i++) chk("final_bank", bank[i], mdl[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
